// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative multiply/divide unit that sits beside the combinational ALU.
// Runs MULT, MULTU, DIV and DIVU one shift-add / restoring-subtract step per
// clock and owns the architectural HI/LO registers (MTHI/MTLO/MFHI/MFLO).
//
// Optional build macro: MULDIV_ABORT_EN adds an `abort` input that cancels an
// in-flight operation without touching HI/LO and without a done pulse.
//
// Parameters:
//   WIDTH  operand / HI / LO width (even, >= 4)
//   CNT_W  iteration counter width (2**CNT_W > WIDTH)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request an operation (accepted in IDLE or DONE)
//   abort        (MULDIV_ABORT_EN only) cancel the operation in progress
//   op           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   operand_a    rs: multiplicand / dividend
//   operand_b    rt: multiplier / divisor
//   hi_we        MTHI strobe (ignored while busy)
//   lo_we        MTLO strobe (ignored while busy)
//   write_data   MTHI/MTLO data
//   busy         operation in progress (PREP, RUN, FIX)
//   done         one-cycle pulse; HI/LO hold the new result
//   div_by_zero  pulses with done when a divide had a zero divisor
//   hi           HI register
//   lo           LO register
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] write_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               is_sgn_q, is_sgn_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;     // |multiplicand| or |divisor|
  logic [W2-1:0]      acc_q, acc_d;       // mul: {partial, multiplier}; div: {rem, quot}
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sgn_quo_q, sgn_quo_d;
  logic               sgn_rem_q, sgn_rem_d;
  logic               dz_q, dz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dzo_q, dzo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Datapath helpers, evaluated every cycle
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [W2-1:0]      prod_fix;

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dzo_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  // Sign handling and one iteration step of either algorithm
  always_comb begin
    neg_a    = is_sgn_q & a_q[WIDTH-1];
    neg_b    = is_sgn_q & b_q[WIDTH-1];
    abs_a    = neg_a ? (~a_q + WIDTH'(1)) : a_q;
    abs_b    = neg_b ? (~b_q + WIDTH'(1)) : b_q;
    // Carry out of the upper-half add is shifted back in on the right shift
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
    // Remainder shifted left with the next dividend bit; needs one extra bit
    rem_sh   = acc_q[W2-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    // When rem_ge holds the true difference is < divisor, so WIDTH bits suffice
    rem_sub  = rem_sh[WIDTH-1:0] - opnd_q;
    quot     = acc_q[WIDTH-1:0];
    rem      = acc_q[W2-1:WIDTH];
    quot_fix = sgn_quo_q ? (~quot + WIDTH'(1)) : quot;
    rem_fix  = sgn_rem_q ? (~rem + WIDTH'(1)) : rem;
    prod_fix = sgn_quo_q ? (~acc_q + W2'(1)) : acc_q;
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    is_sgn_d  = is_sgn_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    dzo_d     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // MTHI/MTLO land even when a start is accepted on the same edge
        if (hi_we) hi_d = write_data;
        if (lo_we) lo_d = write_data;
        if (start) begin
          is_div_d = op[1];
          is_sgn_d = op[0];
          a_d      = operand_a;
          b_d      = operand_b;
          dz_d     = 1'b0;
          state_d  = S_PREP;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_PREP: begin
        sgn_quo_d = neg_a ^ neg_b;
        sgn_rem_d = neg_a;
        cnt_d     = '0;
        if (is_div_q && (b_q == '0)) begin
          dz_d    = 1'b1;
          state_d = S_FIX;
        end else begin
          dz_d    = 1'b0;
          opnd_d  = is_div_q ? abs_b : abs_a;
          acc_d   = {{WIDTH{1'b0}}, (is_div_q ? abs_a : abs_b)};
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          acc_d = rem_ge ? {rem_sub, acc_q[WIDTH-2:0], 1'b1}
                         : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                           : {1'b0, acc_q[W2-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase

`ifdef MULDIV_ABORT_EN
    // Cancel while busy; suppresses the FIX write so HI/LO stay intact
    if (abort && ((state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX))) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
`endif

    busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
    dzo_d  = (state_d == S_DONE) && dz_q;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      is_sgn_q  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dzo_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      is_sgn_q  <= is_sgn_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dzo_q     <= dzo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench: each launched operation pushes its expected HI/LO/flag
// onto a scoreboard; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
`ifdef MULDIV_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] write_data = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef MULDIV_ABORT_EN
    .abort       (abort),
`endif
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .write_data  (write_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the architectural result
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t               r;
    logic [63:0]        p;
    logic signed [63:0] sa, sbv, q, m;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    r   = '0;
    case (o)
      2'b00: begin
        p    = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      2'b01: begin
        p    = 64'(sa * sbv);
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = 32'hFFFF_FFFF;
          r.dz = 1'b1;
        end else if (o == 2'b10) begin
          r.lo = a / b;
          r.hi = a % b;
        end else begin
          q    = sa / sbv;
          m    = sa % sbv;
          r.lo = q[31:0];
          r.hi = m[31:0];
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("sb_hi", 64'(hi), 64'(mon_e.hi));
        check_eq("sb_lo", 64'(lo), 64'(mon_e.lo));
        check_eq("sb_dz", 64'(div_by_zero), 64'(mon_e.dz));
      end
    end
  end

  // Called #1 after an edge; start is sampled at the next edge (E0)
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
    op        = o;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    if (push) sb.push_back(model(o, a, b));
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Wait for done (bounded), checking latency and busy; optional mid-run injection
  task automatic wait_done(input int lat, input bit inj);
    int          n;
    int          blo;
    logic [31:0] lo_before;
    n = 1;
    blo = 0;
    lo_before = lo;
    while (!done && n < 100) begin
      if (busy !== 1'b1) blo++;
      if (inj && n == 5) begin
        lo_before  = lo;
        start      = 1'b1;
        op         = 2'b10;
        operand_a  = 32'd77;
        operand_b  = 32'd5;
        lo_we      = 1'b1;
        write_data = 32'hDEAD_BEEF;
      end
      if (inj && n == 6) begin
        start = 1'b0;
        lo_we = 1'b0;
        check_eq("lo_we_while_busy", 64'(lo), 64'(lo_before));
      end
      @(posedge clk); #1;
      n++;
    end
    check_eq("done_latency", 64'(n), 64'(lat));
    check_eq("busy_low_early", 64'(blo), 64'd0);
    check_eq("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_dz", 64'(div_by_zero), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MTHI in IDLE
    hi_we = 1'b1;
    write_data = 32'h0000_1234;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check_eq("mthi_hi", 64'(hi), 64'h1234);
    check_eq("mthi_lo", 64'(lo), 64'd0);

    // MULTU max x max
    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(35, 1'b0);
    check_eq("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check_eq("multu_lo", 64'(lo), 64'h0000_0001);
    @(posedge clk); #1;

    // MULT -3 x 5
    launch(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(35, 1'b0);
    check_eq("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check_eq("mult_lo", 64'(lo), 64'hFFFF_FFF1);
    @(posedge clk); #1;

    // DIV -7 / 2
    launch(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(35, 1'b0);
    check_eq("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check_eq("div_hi", 64'(hi), 64'hFFFF_FFFF);
    @(posedge clk); #1;

    // DIV overflow case
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(35, 1'b0);
    check_eq("ovf_lo", 64'(lo), 64'h8000_0000);
    check_eq("ovf_hi", 64'(hi), 64'd0);
    check_eq("ovf_dz", 64'(div_by_zero), 64'd0);
    @(posedge clk); #1;

    // DIVU by zero
    launch(2'b10, 32'd100, 32'd0, 1'b1);
    wait_done(3, 1'b0);
    check_eq("dz_flag", 64'(div_by_zero), 64'd1);
    check_eq("dz_hi", 64'(hi), 64'h64);
    check_eq("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    @(posedge clk); #1;

    // MTLO and second start while busy are both ignored
    launch(2'b01, 32'h0001_0003, 32'hFFFF_FF00, 1'b1);
    wait_done(35, 1'b1);
    @(posedge clk); #1;

    // Back-to-back: start accepted in the DONE cycle
    launch(2'b10, 32'd1000, 32'd7, 1'b1);
    wait_done(35, 1'b0);
    launch(2'b11, 32'hFFFF_FC18, 32'd7, 1'b1);
    wait_done(35, 1'b0);
    @(posedge clk); #1;

    // Random operations
    for (int i = 0; i < 8; i++) begin
      launch(2'($urandom_range(3)), $urandom, (i == 3) ? 32'd0 : $urandom, 1'b1);
      wait_done((op[1] && operand_b == 32'd0) ? 3 : 35, 1'b0);
      @(posedge clk); #1;
    end

    // Reset in the middle of a MULTU
    launch(2'b00, 32'd12345, 32'd678, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_hi", 64'(hi), 64'd0);
    check_eq("midrst_lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    repeat (45) @(posedge clk);
    #1;

`ifdef MULDIV_ABORT_EN
    // Abort a DIVU with HI=LO=5 written together beforehand
    hi_we = 1'b1;
    lo_we = 1'b1;
    write_data = 32'd5;
    @(posedge clk); #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    launch(2'b10, 32'd9, 32'd3, 1'b0);
    repeat (11) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_hi", 64'(hi), 64'd5);
    check_eq("abort_lo", 64'(lo), 64'd5);
    repeat (40) @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
